// File: rtl/adc7476a_x2_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc7476a_x2_seq_ctrl
// Brief    : Sequencer for two AD7476A ADCs sharing CS/SCLK; single-shot or
//            rate-paced continuous conversion. Define ADC7476A_SEQ_FRAME_CHECK_EN
//            to flag frames whose 4 leading bits are not zero.
// Revision : 1.0 - initial release
// ============================================================================
module adc7476a_x2_seq_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] rate_div,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    input  logic        adc_sdata_a,
    input  logic        adc_sdata_b,
    output logic [11:0] sample_a,
    output logic [11:0] sample_b,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun,
    output logic        frame_err
);

    // SHIFT is the only state with bit 0 set, so chip select decodes from one flop.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_QUIET = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [7:0]  div_cnt;
    logic [4:0]  half_cnt;
    logic [7:0]  quiet_cnt;
    logic [15:0] rate_cnt;
    logic [15:0] shreg_a;
    logic [15:0] shreg_b;
    logic        enable_q;

    logic tick;
    logic trigger;
    logic half_end;
    logic frame_end;
    logic quiet_end;
    logic in_idle;
    logic in_shift;

    assign tick      = enable && (rate_cnt == rate_div);
    assign trigger   = start || tick;
    assign half_end  = (div_cnt == 8'(CLK_DIV - 1));
    assign frame_end = half_end && (half_cnt == 5'd31);
    assign quiet_end = (quiet_cnt == 8'(QUIET_CYCLES - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (trigger)   state_nxt = S_SHIFT;
            S_SHIFT: if (frame_end) state_nxt = S_QUIET;
            S_QUIET: if (quiet_end) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_idle  = (state == S_IDLE);
        in_shift = (state == S_SHIFT);
        busy     = !in_idle;
        adc_cs_n = !state[0];
    end

    // Serial engine: SCLK half-period timing, MSB-first capture on SCLK rise.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            adc_sclk     <= 1'b1;
            div_cnt      <= 8'd0;
            half_cnt     <= 5'd0;
            quiet_cnt    <= 8'd0;
            shreg_a      <= 16'd0;
            shreg_b      <= 16'd0;
            sample_a     <= 12'd0;
            sample_b     <= 12'd0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    div_cnt  <= 8'd0;
                    half_cnt <= 5'd0;
                    if (trigger) adc_sclk <= 1'b0;
                end
                S_SHIFT: begin
                    quiet_cnt <= 8'd0;
                    if (half_end) begin
                        div_cnt  <= 8'd0;
                        half_cnt <= half_cnt + 5'd1;
                        if (!adc_sclk) begin
                            shreg_a <= {shreg_a[14:0], adc_sdata_a};
                            shreg_b <= {shreg_b[14:0], adc_sdata_b};
                        end
                        if (frame_end) begin
                            adc_sclk     <= 1'b1;
                            sample_a     <= shreg_a[11:0];
                            sample_b     <= shreg_b[11:0];
                            sample_valid <= 1'b1;
                        end else begin
                            adc_sclk <= !adc_sclk;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_QUIET: begin
                    quiet_cnt <= quiet_cnt + 8'd1;
                end
                default: begin
                    adc_sclk <= 1'b1;
                end
            endcase
        end
    end

    // Overrun clears on the falling edge of enable so single-shot losses stay visible.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            enable_q <= 1'b0;
            rate_cnt <= 16'd0;
            overrun  <= 1'b0;
        end else begin
            enable_q <= enable;
            if (!enable || (rate_cnt == rate_div)) begin
                rate_cnt <= 16'd0;
            end else begin
                rate_cnt <= rate_cnt + 16'd1;
            end
            if (trigger && !in_idle) begin
                overrun <= 1'b1;
            end else if (enable_q && !enable) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef ADC7476A_SEQ_FRAME_CHECK_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            frame_err <= 1'b0;
        end else if (in_shift && frame_end &&
                     ((|shreg_a[15:12]) || (|shreg_b[15:12]))) begin
            frame_err <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc7476a_x2_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc7476a_x2_seq_ctrl
// Brief    : Directed bench: frame vector table on a CLK_DIV=4 instance, plus
//            reset, overrun and continuous-rate sequences (CLK_DIV=2 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc7476a_x2_seq_ctrl;

`ifdef ADC7476A_SEQ_FRAME_CHECK_EN
    localparam logic FC = 1'b1;
`else
    localparam logic FC = 1'b0;
`endif

    logic        ACLK    = 1'b0;
    logic        ARESETN = 1'b1;
    always #5 ACLK = ~ACLK;

    logic        enable = 1'b0, start = 1'b0;
    logic [15:0] rate_div = 16'd0;
    logic        adc_cs_n, adc_sclk, adc_sdata_a, adc_sdata_b;
    logic [11:0] sample_a, sample_b;
    logic        sample_valid, busy, overrun, frame_err;

    logic        enable2 = 1'b0, start2 = 1'b0;
    logic [15:0] rate_div2 = 16'd0;
    logic        adc_cs_n2, adc_sclk2;
    logic [11:0] sample_a2, sample_b2;
    logic        sample_valid2, busy2, overrun2, frame_err2;

    adc7476a_x2_seq_ctrl #(.CLK_DIV(4), .QUIET_CYCLES(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .start(start),
        .rate_div(rate_div), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
        .adc_sdata_a(adc_sdata_a), .adc_sdata_b(adc_sdata_b),
        .sample_a(sample_a), .sample_b(sample_b), .sample_valid(sample_valid),
        .busy(busy), .overrun(overrun), .frame_err(frame_err)
    );

    adc7476a_x2_seq_ctrl #(.CLK_DIV(2), .QUIET_CYCLES(4)) dut2 (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable2), .start(start2),
        .rate_div(rate_div2), .adc_cs_n(adc_cs_n2), .adc_sclk(adc_sclk2),
        .adc_sdata_a(1'b1), .adc_sdata_b(1'b0),
        .sample_a(sample_a2), .sample_b(sample_b2), .sample_valid(sample_valid2),
        .busy(busy2), .overrun(overrun2), .frame_err(frame_err2)
    );

    // ADC model: bit 15 presented at CS fall, advances after each SCLK rise.
    logic [15:0] frame_a = 16'd0, frame_b = 16'd0;
    logic [4:0]  idx = 5'd0;
    always @(posedge adc_sclk or posedge adc_cs_n) begin
        if (adc_cs_n) idx <= 5'd0;
        else          idx <= idx + 5'd1;
    end
    assign adc_sdata_a = (!adc_cs_n && idx < 5'd16) ? frame_a[4'd15 - idx[3:0]] : 1'b0;
    assign adc_sdata_b = (!adc_cs_n && idx < 5'd16) ? frame_b[4'd15 - idx[3:0]] : 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulses start, then observes #1 after each edge; latency counts from the start edge.
    task automatic run_frame(input logic [15:0] fa, input logic [15:0] fb,
                             output int lat, output int lows, output int rises,
                             output int quiet, output int vlen);
        logic prev;
        frame_a = fa; frame_b = fb;
        lat = -1; lows = 0; rises = 0; quiet = 0; vlen = 0; prev = 1'b1;
        @(negedge ACLK); start = 1'b1;
        @(posedge ACLK); #1; start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!adc_cs_n) lows++;
            if (!prev && adc_sclk) rises++;
            prev = adc_sclk;
            if (sample_valid) begin
                lat = k + 1;
                break;
            end
            @(posedge ACLK); #1;
        end
        for (int q = 0; q < 50; q++) begin
            if (!busy) break;
            quiet++;
            if (sample_valid) vlen++;
            @(posedge ACLK); #1;
        end
    endtask

    typedef struct {
        logic [15:0] frame_a;
        logic [15:0] frame_b;
        logic [11:0] exp_a;
        logic [11:0] exp_b;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, lows, rises, quiet, vlen, cnt;
        int falls[4];
        int nfall, nvalid, first_valid;
        logic prev2, ovr_seen;

        vecs[0] = '{16'h0ABC, 16'h0123, 12'hABC, 12'h123, 1'b0};
        vecs[1] = '{16'h0FFF, 16'h0000, 12'hFFF, 12'h000, 1'b0};
        vecs[2] = '{16'h0000, 16'h0FFF, 12'h000, 12'hFFF, 1'b0};
        vecs[3] = '{16'h0555, 16'h0AAA, 12'h555, 12'hAAA, 1'b0};
        vecs[4] = '{16'h0321, 16'h8123, 12'h321, 12'h123, FC};
        vecs[5] = '{16'h0456, 16'h0789, 12'h456, 12'h789, FC};

        // Asynchronous reset: outputs must settle before any clock edge.
        #1 ARESETN = 1'b0;
        #1;
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_samples", {sample_a, sample_b}, 0);
        check("rst_cs_n2", adc_cs_n2, 1);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);

        foreach (vecs[i]) begin
            run_frame(vecs[i].frame_a, vecs[i].frame_b, lat, lows, rises, quiet, vlen);
            check($sformatf("v%0d_latency", i), lat, 129);
            check($sformatf("v%0d_cs_low", i), lows, 128);
            check($sformatf("v%0d_sclk_periods", i), rises, 16);
            check($sformatf("v%0d_quiet", i), quiet, 4);
            check($sformatf("v%0d_valid_len", i), vlen, 1);
            check($sformatf("v%0d_sample_a", i), sample_a, vecs[i].exp_a);
            check($sformatf("v%0d_sample_b", i), sample_b, vecs[i].exp_b);
            check($sformatf("v%0d_frame_err", i), frame_err, vecs[i].exp_ferr);
            repeat (7) @(posedge ACLK);
            #1;
            check($sformatf("v%0d_hold", i), {sample_a, sample_b}, {vecs[i].exp_a, vecs[i].exp_b});
        end

        // Reset in the middle of bit 7 (7th SCLK rise is 52 edges after start).
        frame_a = 16'h0FFF; frame_b = 16'h0FFF;
        @(negedge ACLK); start = 1'b1;
        @(posedge ACLK); #1; start = 1'b0;
        repeat (56) @(posedge ACLK);
        #2;
        check("mid_shift_cs_low", adc_cs_n, 0);
        ARESETN = 1'b0;
        #1;
        check("mid_rst_cs_n", adc_cs_n, 1);
        check("mid_rst_sclk", adc_sclk, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_samples", {sample_a, sample_b}, 0);
        check("mid_rst_flags", {sample_valid, overrun, frame_err}, 0);
        @(negedge ACLK); ARESETN = 1'b1;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge ACLK); #1;
            if (sample_valid || !adc_cs_n) cnt++;
        end
        check("no_activity_after_rst", cnt, 0);
        run_frame(16'h0ABC, 16'h0123, lat, lows, rises, quiet, vlen);
        check("post_rst_latency", lat, 129);
        check("post_rst_samples", {sample_a, sample_b}, {12'hABC, 12'h123});
        check("post_rst_frame_err", frame_err, 0);

        // Overrun: back-to-back ticks plus a start during SHIFT.
        check("ovr_initial", overrun, 0);
        @(negedge ACLK); rate_div = 16'd0; enable = 1'b1;
        repeat (20) @(negedge ACLK);
        start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        check("ovr_in_shift", adc_cs_n, 0);
        check("ovr_set", overrun, 1);
        repeat (200) @(negedge ACLK);
        check("ovr_sticky", overrun, 1);
        check("ovr_busy_at_disable", busy, 1);
        enable = 1'b0;
        @(posedge ACLK); #1;
        check("ovr_cleared", overrun, 0);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (sample_valid) begin
                cnt = 1;
                break;
            end
            @(posedge ACLK); #1;
        end
        check("disable_completes", cnt, 1);
        repeat (6) @(posedge ACLK);
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge ACLK); #1;
            if (!adc_cs_n) cnt++;
        end
        check("no_conv_after_disable", cnt, 0);
        check("ovr_final", overrun, 0);

        // Continuous mode on the CLK_DIV=2 instance; start coincides with the 2nd tick.
        nfall = 0; nvalid = 0; first_valid = -1; ovr_seen = 1'b0; prev2 = 1'b1;
        @(negedge ACLK); rate_div2 = 16'd300; enable2 = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge ACLK); #1;
            if (prev2 && !adc_cs_n2 && nfall < 4) begin
                falls[nfall] = k;
                nfall++;
            end
            prev2 = adc_cs_n2;
            if (sample_valid2) begin
                if (first_valid < 0) first_valid = k;
                nvalid++;
            end
            if (overrun2) ovr_seen = 1'b1;
            if (k == 601) start2 = 1'b1;
            if (k == 602) start2 = 1'b0;
        end
        enable2 = 1'b0;
        check("cont_nfall", nfall, 3);
        check("cont_first", falls[0], 301);
        check("cont_period1", falls[1] - falls[0], 301);
        check("cont_period2", falls[2] - falls[1], 301);
        check("cont_first_valid", first_valid, 365);
        check("cont_nvalid", nvalid, 3);
        check("cont_no_overrun", ovr_seen, 0);
        check("cont_samples", {sample_a2, sample_b2}, {12'hFFF, 12'h000});
        check("cont_frame_err", frame_err2, FC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
